// File: rtl/iomem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_rr_arbiter
// Two-master arbiter in front of one PicoRV32-native valid/ready port.
// m0 is the CPU, m1 is the SHA-256 DMA. One transaction is owned at a time and
// held until the slave returns ready. Round-robin between simultaneous
// requests, or m0-priority when FIXED_PRIO=1.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a BUSY cycle counter forces completion after TIMEOUT_CYCLES
//   with read data 32'hDEAD_BEEF and sets the sticky err flag.
//   When undefined, BUSY waits indefinitely and err is tied low.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   m{0,1}_valid/addr/wdata/wstrb  master request (held stable until ready)
//   m{0,1}_ready/rdata          master completion pulse and read data
//   s_valid/addr/wdata/wstrb    muxed slave request
//   s_ready/rdata               slave completion and read data
//   grant                       one-hot current owner, 0 when idle
//   err                         sticky timeout flag
// -----------------------------------------------------------------------------
module iomem_rr_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // The wait counter is at most 16 bits wide
  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;    // index of the master that completed most recently

  logic       gnt_valid_c;       // granted master still requesting
  logic       gnt_idx_c;         // index of granted master
  logic       timeout_c;         // forced completion this cycle

  assign gnt_idx_c   = grant_q[1];
  assign gnt_valid_c = (grant_q[0] & m0_valid) | (grant_q[1] & m1_valid);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter holds the number of completed BUSY wait cycles, so the limit is hit
  // in BUSY cycle TIMEOUT_CYCLES when it reads TIMEOUT_CYCLES-1.
  assign timeout_c = (state_q == ST_BUSY) & gnt_valid_c & ~s_ready &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared while idle (i.e. at grant), counts stalled BUSY cycles
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_c;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (!s_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, release on completion or abandoned request
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ST_BUSY;
          if (m0_valid && m1_valid) begin
            // last_q=1 means m1 went last, so m0 is next in rotation
            grant_d = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
          end else begin
            grant_d = m0_valid ? 2'b01 : 2'b10;
          end
        end
      end
      ST_BUSY: begin
        if (!gnt_valid_c) begin
          // Requester withdrew: drop the grant without touching the rotation
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else if (s_ready || timeout_c) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = gnt_idx_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave-side mux: zeros when nobody owns the port
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (grant_q[0]) begin
      s_addr  = AW'(m0_addr);
      s_wdata = DW'(m0_wdata);
      s_wstrb = SW'(m0_wstrb);
    end else if (grant_q[1]) begin
      s_addr  = AW'(m1_addr);
      s_wdata = DW'(m1_wdata);
      s_wstrb = SW'(m1_wstrb);
    end
    s_valid = (state_q == ST_BUSY) & gnt_valid_c & ~timeout_c;
  end

  // Master-side return path; ready is suppressed for a withdrawn request
  assign m0_ready = grant_q[0] & gnt_valid_c & (s_ready | timeout_c);
  assign m1_ready = grant_q[1] & gnt_valid_c & (s_ready | timeout_c);
  assign m0_rdata = grant_q[0] ? (timeout_c ? TIMEOUT_RDATA : s_rdata) : '0;
  assign m1_rdata = grant_q[1] ? (timeout_c ? TIMEOUT_RDATA : s_rdata) : '0;

  assign grant = grant_q;

endmodule
